pc_redirect_unit: RTL and testbench

- Consumer end of the branch-offset path. Owns the fetch program counter and advances it sequentially.
- Accepts the resolved branch/jal/jalr offset from the decoder and the PC of the resolving instruction, then computes the redirect target.
- Reloads the PC, squashes wrong-path instructions with a counted flush, and traps misaligned targets. Sits between the decode/EX stage and instruction fetch.

---
 rtl/pc_redirect_unit.sv | 116 +++++++++++
 tb/tb_pc_redirect_unit.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/pc_redirect_unit.sv
// Fetch PC owner: steps sequentially, reloads on resolved jal/jalr/branch targets,
// squashes wrong-path fetches with a counted flush and traps misaligned targets.
module pc_redirect_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC     = 32'h0000_0100,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter bit          COMP_EN      = 1'b1
) (
    input  logic        clk,
    input  logic        Rst,
    input  logic        stall,
    input  logic        fetch_comp,
    input  logic        brnch_taken,
    input  logic        jal,
    input  logic        jalr,
    input  logic [31:0] pc_ex,
    input  logic [31:0] branoff,
    output logic [31:0] pc_if,
    output logic        flush,
    output logic        redirect,
    output logic        exc_misalign,
    output logic [31:0] exc_addr
);

    localparam logic [0:0] RUN   = 1'b0;
    localparam logic [0:0] FLUSH = 1'b1;
    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    logic [0:0]  state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] pc_q, pc_d;
    logic        flush_q, flush_d;
    logic        redirect_q, redirect_d;
    logic        exc_q, exc_d;
    logic [31:0] exc_addr_q, exc_addr_d;

    logic [31:0] target;
    logic [31:0] seq_pc;
    logic        misaligned;
    logic        req;

    // jal wins over jalr; branch shares the PC-relative adder with jal.
    always_comb begin
        target = pc_ex + branoff;
        if (jalr && !jal) begin
            target = {branoff[31:1], 1'b0};
        end
        misaligned = COMP_EN ? target[0] : (target[1] | target[0]);
        req        = (state_q == RUN) && (jal || jalr || brnch_taken);
        seq_pc     = stall ? pc_q : (pc_q + (fetch_comp ? 32'd2 : 32'd4));
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pc_d       = seq_pc;
        flush_d    = 1'b0;
        redirect_d = 1'b0;
        exc_d      = 1'b0;
        exc_addr_d = exc_addr_q;
        case (state_q)
            RUN: begin
                if (req) begin
                    pc_d       = misaligned ? TRAP_VEC : target;
                    redirect_d = !misaligned;
                    exc_d      = misaligned;
                    if (misaligned) begin
                        exc_addr_d = target;
                    end
                    flush_d = 1'b1;
                    cnt_d   = FLUSH_LOAD;
                    state_d = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
                end
            end
            FLUSH: begin
                // Inputs here belong to squashed instructions; only the counter matters.
                if (cnt_q == 3'd0) begin
                    state_d = RUN;
                end else begin
                    cnt_d   = cnt_q - 3'd1;
                    flush_d = 1'b1;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (Rst) begin
            state_q    <= RUN;
            cnt_q      <= 3'd0;
            pc_q       <= RESET_PC;
            flush_q    <= 1'b0;
            redirect_q <= 1'b0;
            exc_q      <= 1'b0;
            exc_addr_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pc_q       <= pc_d;
            flush_q    <= flush_d;
            redirect_q <= redirect_d;
            exc_q      <= exc_d;
            exc_addr_q <= exc_addr_d;
        end
    end

    assign pc_if        = pc_q;
    assign flush        = flush_q;
    assign redirect     = redirect_q;
    assign exc_misalign = exc_q;
    assign exc_addr     = exc_addr_q;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed bench for pc_redirect_unit: one instance with compressed support,
// one with 4-byte alignment, both fed the same stimulus.
module tb_pc_redirect_unit;

    logic        clk = 1'b0;
    logic        Rst, stall, fetch_comp, brnch_taken, jal, jalr;
    logic [31:0] pc_ex, branoff;

    logic [31:0] pc_c, exc_addr_c, pc_w, exc_addr_w;
    logic        flush_c, redirect_c, exc_c, flush_w, redirect_w, exc_w;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pc_redirect_unit #(.COMP_EN(1'b1)) dut (
        .clk(clk), .Rst(Rst), .stall(stall), .fetch_comp(fetch_comp),
        .brnch_taken(brnch_taken), .jal(jal), .jalr(jalr),
        .pc_ex(pc_ex), .branoff(branoff),
        .pc_if(pc_c), .flush(flush_c), .redirect(redirect_c),
        .exc_misalign(exc_c), .exc_addr(exc_addr_c)
    );

    pc_redirect_unit #(.COMP_EN(1'b0)) dut4 (
        .clk(clk), .Rst(Rst), .stall(stall), .fetch_comp(fetch_comp),
        .brnch_taken(brnch_taken), .jal(jal), .jalr(jalr),
        .pc_ex(pc_ex), .branoff(branoff),
        .pc_if(pc_w), .flush(flush_w), .redirect(redirect_w),
        .exc_misalign(exc_w), .exc_addr(exc_addr_w)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, then advance to just after the next rising edge.
    task automatic applyStimulus(input logic r, input logic st, input logic fc,
                                 input logic j, input logic jr, input logic br,
                                 input logic [31:0] pex, input logic [31:0] off);
        Rst = r; stall = st; fetch_comp = fc;
        jal = j; jalr = jr; brnch_taken = br;
        pc_ex = pex; branoff = off;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic st, input logic fc);
        applyStimulus(1'b0, st, fc, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        // Reset and sequential stepping
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h40, 32'h4);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("rst_pc", pc_c, 32'h0);
        checkOutput("rst_flush", {31'b0, flush_c}, 32'h0);
        checkOutput("rst_redirect", {31'b0, redirect_c}, 32'h0);
        checkOutput("rst_exc", {31'b0, exc_c}, 32'h0);
        checkOutput("rst_exc_addr", exc_addr_c, 32'h0);
        idle(1'b0, 1'b0);
        checkOutput("seq_pc4", pc_c, 32'h4);
        idle(1'b0, 1'b0);
        checkOutput("seq_pc8", pc_c, 32'h8);
        checkOutput("seq_flush", {31'b0, flush_c}, 32'h0);

        // Backward branch: 0x40 + (-16)
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h40, 32'hFFFF_FFF0);
        checkOutput("br_pc", pc_c, 32'h30);
        checkOutput("br_redirect", {31'b0, redirect_c}, 32'h1);
        checkOutput("br_flush1", {31'b0, flush_c}, 32'h1);
        checkOutput("br_exc", {31'b0, exc_c}, 32'h0);
        idle(1'b0, 1'b0);
        checkOutput("br_pc34", pc_c, 32'h34);
        checkOutput("br_redirect_pulse", {31'b0, redirect_c}, 32'h0);
        checkOutput("br_flush2", {31'b0, flush_c}, 32'h1);
        idle(1'b0, 1'b0);
        checkOutput("br_pc38", pc_c, 32'h38);
        checkOutput("br_flush_end", {31'b0, flush_c}, 32'h0);

        // jalr beats branch, bit 0 cleared
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h80, 32'h0000_1235);
        checkOutput("jalr_pc", pc_c, 32'h1234);
        checkOutput("jalr_redirect", {31'b0, redirect_c}, 32'h1);
        checkOutput("jalr_pc_w", pc_w, 32'h1234);
        idle(1'b0, 1'b0);
        idle(1'b0, 1'b0);
        checkOutput("jalr_after", pc_c, 32'h123C);

        // jal beats jalr: 0x80 + 0x1235 is odd -> trap on both variants
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h80, 32'h0000_1235);
        checkOutput("jal_trap_pc", pc_c, 32'h100);
        checkOutput("jal_trap_exc", {31'b0, exc_c}, 32'h1);
        checkOutput("jal_trap_addr", exc_addr_c, 32'h12B5);
        checkOutput("jal_trap_redirect", {31'b0, redirect_c}, 32'h0);
        checkOutput("jal_trap_flush", {31'b0, flush_c}, 32'h1);
        idle(1'b0, 1'b0);
        checkOutput("trap_exc_pulse", {31'b0, exc_c}, 32'h0);
        checkOutput("trap_addr_held", exc_addr_c, 32'h12B5);
        checkOutput("trap_pc104", pc_c, 32'h104);
        idle(1'b0, 1'b0);
        checkOutput("trap_flush_end", {31'b0, flush_c}, 32'h0);

        // 0x106: aligned for 2-byte fetch, misaligned for 4-byte-only
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h100, 32'h6);
        checkOutput("mis_w_pc", pc_w, 32'h100);
        checkOutput("mis_w_exc", {31'b0, exc_w}, 32'h1);
        checkOutput("mis_w_addr", exc_addr_w, 32'h106);
        checkOutput("mis_w_redirect", {31'b0, redirect_w}, 32'h0);
        checkOutput("mis_w_flush", {31'b0, flush_w}, 32'h1);
        checkOutput("mis_c_pc", pc_c, 32'h106);
        checkOutput("mis_c_redirect", {31'b0, redirect_c}, 32'h1);
        idle(1'b0, 1'b0);
        checkOutput("mis_w_flush2", {31'b0, flush_w}, 32'h1);
        checkOutput("mis_w_pc104", pc_w, 32'h104);
        idle(1'b0, 1'b0);
        checkOutput("mis_w_flush_end", {31'b0, flush_w}, 32'h0);
        checkOutput("mis_c_pc10e", pc_c, 32'h10E);

        // Stall holds, compressed steps by 2
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b0);
        checkOutput("stall_hold", pc_c, 32'h10E);
        idle(1'b0, 1'b1);
        checkOutput("comp_step", pc_c, 32'h110);
        checkOutput("comp_step_w", pc_w, 32'h10A);

        // Branch taken under stall, then jal during flush is ignored
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h200, 32'h20);
        checkOutput("stall_br_pc", pc_c, 32'h220);
        checkOutput("stall_br_redirect", {31'b0, redirect_c}, 32'h1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h500, 32'h0);
        checkOutput("mask_pc224", pc_c, 32'h224);
        checkOutput("mask_redirect", {31'b0, redirect_c}, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h500, 32'h0);
        checkOutput("mask_pc228", pc_c, 32'h228);
        checkOutput("mask_redirect2", {31'b0, redirect_c}, 32'h0);
        checkOutput("mask_flush_end", {31'b0, flush_c}, 32'h0);

        // Reset in the first flush cycle
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h40, 32'h10);
        checkOutput("mid_pc", pc_c, 32'h50);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("mid_rst_pc", pc_c, 32'h0);
        checkOutput("mid_rst_flush", {31'b0, flush_c}, 32'h0);
        idle(1'b0, 1'b0);
        checkOutput("mid_run_pc", pc_c, 32'h4);
        checkOutput("mid_run_flush", {31'b0, flush_c}, 32'h0);

        // Redirect to the top of the address space, then wrap
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'hFFFF_FFFC);
        checkOutput("wrap_target", pc_c, 32'hFFFF_FFFC);
        idle(1'b0, 1'b0);
        checkOutput("wrap_pc0", pc_c, 32'h0);
        checkOutput("wrap_pc0_w", pc_w, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL timeout: got running expected finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
